// File: rtl/ifetch_wide_data_stage_if.sv
// Lookup, line/tag fill, rollback and fetch-result bundle for ifetch_wide_data_stage.
// The tag stage / testbench drives the master side; the data stage uses the slave side.
interface ifetch_wide_data_stage_if #(
  parameter int NUM_WAYS    = 4,
  parameter int NUM_SETS    = 64,
  parameter int FETCH_WORDS = 2,
  parameter int NUM_THREADS = 4
);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int TAG_W = 26 - SET_W;
  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic                             ift_instruction_requested;
  logic [31:0]                      ift_pc_paddr;
  logic [31:0]                      ift_pc_vaddr;
  logic [TID_W-1:0]                 ift_thread_idx;
  logic                             ift_tlb_hit;
  logic [NUM_WAYS-1:0][TAG_W-1:0]   ift_tag;
  logic [NUM_WAYS-1:0]              ift_valid;

  logic                             l2i_idata_update_en;
  logic [WAY_W-1:0]                 l2i_idata_update_way;
  logic [SET_W-1:0]                 l2i_idata_update_set;
  logic [511:0]                     l2i_idata_update_data;
  logic [NUM_WAYS-1:0]              l2i_itag_update_en;
  logic [SET_W-1:0]                 l2i_itag_update_set;
  logic [TAG_W-1:0]                 l2i_itag_update_tag;

  logic                             wb_rollback_en;
  logic [TID_W-1:0]                 wb_rollback_thread_idx;

  logic [FETCH_WORDS-1:0][31:0]     ifd_instruction;
  logic [FETCH_WORDS-1:0]           ifd_word_valid;
  logic [31:0]                      ifd_pc;
  logic [TID_W-1:0]                 ifd_thread_idx;
  logic                             ifd_alignment_fault;
  logic                             ifd_cache_miss;
  logic [25:0]                      ifd_cache_miss_paddr;
  logic [TID_W-1:0]                 ifd_cache_miss_thread_idx;
  logic                             ifd_near_miss;
  logic                             ifd_update_lru_en;
  logic [WAY_W-1:0]                 ifd_update_lru_way;
  logic                             ifd_invalidate_en;
  logic [WAY_W-1:0]                 ifd_invalidate_way;
  logic [SET_W-1:0]                 ifd_invalidate_set;
  logic                             ifd_parity_error;
  logic [NUM_THREADS-1:0]           ifd_machine_check;

  modport master (
    output ift_instruction_requested, ift_pc_paddr, ift_pc_vaddr, ift_thread_idx,
           ift_tlb_hit, ift_tag, ift_valid,
           l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set,
           l2i_idata_update_data, l2i_itag_update_en, l2i_itag_update_set,
           l2i_itag_update_tag, wb_rollback_en, wb_rollback_thread_idx,
    input  ifd_instruction, ifd_word_valid, ifd_pc, ifd_thread_idx, ifd_alignment_fault,
           ifd_cache_miss, ifd_cache_miss_paddr, ifd_cache_miss_thread_idx, ifd_near_miss,
           ifd_update_lru_en, ifd_update_lru_way, ifd_invalidate_en, ifd_invalidate_way,
           ifd_invalidate_set, ifd_parity_error, ifd_machine_check
  );

  modport slave (
    input  ift_instruction_requested, ift_pc_paddr, ift_pc_vaddr, ift_thread_idx,
           ift_tlb_hit, ift_tag, ift_valid,
           l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set,
           l2i_idata_update_data, l2i_itag_update_en, l2i_itag_update_set,
           l2i_itag_update_tag, wb_rollback_en, wb_rollback_thread_idx,
    output ifd_instruction, ifd_word_valid, ifd_pc, ifd_thread_idx, ifd_alignment_fault,
           ifd_cache_miss, ifd_cache_miss_paddr, ifd_cache_miss_thread_idx, ifd_near_miss,
           ifd_update_lru_en, ifd_update_lru_way, ifd_invalidate_en, ifd_invalidate_way,
           ifd_invalidate_set, ifd_parity_error, ifd_machine_check
  );
endinterface

// File: rtl/ifetch_wide_data_stage.sv
// Wide-fetch L1I data stage: way select, line read, slot extraction, miss/near-miss reporting.
// Define IFETCH_PARITY_EN to add per-word even parity, per-thread recovery FSMs and machine-check.
module ifetch_wide_data_stage #(
  parameter int NUM_WAYS    = 4,
  parameter int NUM_SETS    = 64,
  parameter int FETCH_WORDS = 2,
  parameter int NUM_THREADS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  ifetch_wide_data_stage_if.slave bus
);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int TAG_W = 26 - SET_W;
  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int IDX_W = WAY_W + SET_W;
  localparam int LINES = 2 ** IDX_W;

  logic [SET_W-1:0]             lookup_set;
  logic [TAG_W-1:0]             lookup_tag;
  logic [WAY_W-1:0]             hit_way;
  logic                         way_hit_any;
  logic                         lookup_blocked;
  logic                         hit;
  logic                         squash;
  logic                         near_miss;
  logic                         cache_miss;

  logic [511:0]                 data_mem [LINES];
  logic [511:0]                 line_q;
  logic [IDX_W-1:0]             rd_idx;
  logic [IDX_W-1:0]             wr_idx;

  logic                         req_q;
  logic                         hit_q;
  logic                         squash_q;
  logic                         misalign_q;
  logic                         fault_q;
  logic                         miss_q;
  logic [WAY_W-1:0]             way_q;
  logic [SET_W-1:0]             set_q;
  logic [TID_W-1:0]             tid_q;
  logic [31:0]                  pc_q;
  logic [3:0]                   word_off_q;
  logic [25:0]                  miss_paddr_q;

  logic [FETCH_WORDS-1:0][31:0] instr;
  logic [FETCH_WORDS-1:0]       in_line;
  logic [FETCH_WORDS-1:0]       word_valid;
  logic [4:0]                   widx;
  logic [31:0]                  word;
  logic                         par_err;

`ifdef IFETCH_PARITY_EN
  typedef enum logic {RUN, RECOVER} thread_state_e;

  thread_state_e          state_q       [NUM_THREADS];
  thread_state_e          state_d       [NUM_THREADS];
  logic [SET_W-1:0]       recover_set_q [NUM_THREADS];
  logic [SET_W-1:0]       recover_set_d [NUM_THREADS];
  logic [1:0]             retry_q       [NUM_THREADS];
  logic [1:0]             retry_d       [NUM_THREADS];
  logic [NUM_THREADS-1:0] mcheck_q;
  logic [NUM_THREADS-1:0] mcheck_d;
  logic [15:0]            par_mem [LINES];
  logic [15:0]            fill_par;
  logic [15:0]            par_q;
  logic                   parity_bad;

  // A thread waiting for its corrupted line to be refilled must not hit in the stale copy.
  assign lookup_blocked = (state_q[bus.ift_thread_idx] == RECOVER);
`else
  assign lookup_blocked = 1'b0;
`endif

  assign lookup_set = bus.ift_pc_paddr[6 +: SET_W];
  assign lookup_tag = bus.ift_pc_paddr[31 -: TAG_W];

  // Descending scan so the lowest-numbered matching way wins if tags are ever duplicated.
  always_comb begin
    way_hit_any = 1'b0;
    hit_way     = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (bus.ift_valid[w] && bus.ift_tag[w] == lookup_tag) begin
        way_hit_any = 1'b1;
        hit_way     = WAY_W'(w);
      end
    end
  end

  assign hit        = way_hit_any && bus.ift_tlb_hit && !lookup_blocked;
  assign squash     = bus.wb_rollback_en && (bus.wb_rollback_thread_idx == bus.ift_thread_idx);
  assign near_miss  = bus.ift_instruction_requested && bus.ift_tlb_hit && !hit &&
                      (|bus.l2i_itag_update_en) &&
                      (bus.l2i_itag_update_set == lookup_set) &&
                      (bus.l2i_itag_update_tag == lookup_tag);
  assign cache_miss = bus.ift_instruction_requested && bus.ift_tlb_hit && !hit &&
                      !near_miss && !squash;

  assign rd_idx = {hit_way, lookup_set};
  assign wr_idx = {bus.l2i_idata_update_way, bus.l2i_idata_update_set};

  // Line storage has no reset; a same-index fill bypasses to the read port.
  always_ff @(posedge clk) begin
    if (bus.l2i_idata_update_en)
      data_mem[wr_idx] <= bus.l2i_idata_update_data;
    line_q <= (bus.l2i_idata_update_en && wr_idx == rd_idx) ?
              bus.l2i_idata_update_data : data_mem[rd_idx];
  end

`ifdef IFETCH_PARITY_EN
  always_comb begin
    fill_par = '0;
    for (int w = 0; w < 16; w++)
      fill_par[w] = ^bus.l2i_idata_update_data[w*32 +: 32];
  end

  always_ff @(posedge clk) begin
    if (bus.l2i_idata_update_en)
      par_mem[wr_idx] <= fill_par;
    par_q <= (bus.l2i_idata_update_en && wr_idx == rd_idx) ? fill_par : par_mem[rd_idx];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q      <= 1'b0;
      hit_q      <= 1'b0;
      squash_q   <= 1'b0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      req_q      <= bus.ift_instruction_requested;
      hit_q      <= hit;
      squash_q   <= squash;
      misalign_q <= |bus.ift_pc_paddr[1:0];
      fault_q    <= bus.ift_instruction_requested && !squash && (|bus.ift_pc_paddr[1:0]);
      miss_q     <= cache_miss;
    end
  end

  always_ff @(posedge clk) begin
    way_q        <= hit_way;
    set_q        <= lookup_set;
    tid_q        <= bus.ift_thread_idx;
    pc_q         <= bus.ift_pc_vaddr;
    word_off_q   <= bus.ift_pc_paddr[5:2];
    miss_paddr_q <= bus.ift_pc_paddr[31:6];
  end

  // Slots past word 15 fall off the end of the line and are never wrapped.
  always_comb begin
    instr   = '0;
    in_line = '0;
    widx    = '0;
    word    = '0;
`ifdef IFETCH_PARITY_EN
    parity_bad = 1'b0;
`endif
    for (int k = 0; k < FETCH_WORDS; k++) begin
      widx = {1'b0, word_off_q} + 5'(k);
      if (!widx[4]) begin
        in_line[k] = 1'b1;
        word       = line_q[32*widx[3:0] +: 32];
        instr[k]   = {word[7:0], word[15:8], word[23:16], word[31:24]};
`ifdef IFETCH_PARITY_EN
        if ((^word) != par_q[widx[3:0]])
          parity_bad = 1'b1;
`endif
      end
    end
  end

`ifdef IFETCH_PARITY_EN
  // Parity is checked even on squashed fetches so a corrupted line is always invalidated.
  assign par_err = req_q && hit_q && parity_bad;
`else
  assign par_err = 1'b0;
`endif

  assign word_valid = {FETCH_WORDS{req_q && hit_q && !squash_q && !misalign_q && !par_err}} &
                      in_line;

`ifdef IFETCH_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t]       <= RUN;
        recover_set_q[t] <= '0;
        retry_q[t]       <= 2'd0;
      end
      mcheck_q <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t]       <= state_d[t];
        recover_set_q[t] <= recover_set_d[t];
        retry_q[t]       <= retry_d[t];
      end
      mcheck_q <= mcheck_d;
    end
  end

  // Retry counter saturates at 3; reaching 3 latches machine-check until reset.
  always_comb begin
    mcheck_d = mcheck_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      state_d[t]       = state_q[t];
      recover_set_d[t] = recover_set_q[t];
      retry_d[t]       = retry_q[t];
      if (par_err && tid_q == TID_W'(t)) begin
        state_d[t]       = RECOVER;
        recover_set_d[t] = set_q;
        if (retry_q[t] != 2'd3)
          retry_d[t] = retry_q[t] + 2'd1;
      end else begin
        if (state_q[t] == RECOVER && bus.l2i_idata_update_en &&
            bus.l2i_idata_update_set == recover_set_q[t])
          state_d[t] = RUN;
        if (tid_q == TID_W'(t) && (|word_valid))
          retry_d[t] = 2'd0;
      end
      mcheck_d[t] = mcheck_q[t] | (retry_d[t] == 2'd3);
    end
  end

  assign bus.ifd_machine_check = mcheck_q;
`else
  assign bus.ifd_machine_check = '0;
`endif

  assign bus.ifd_instruction           = instr;
  assign bus.ifd_word_valid            = word_valid;
  assign bus.ifd_pc                    = pc_q;
  assign bus.ifd_thread_idx            = tid_q;
  assign bus.ifd_alignment_fault       = fault_q;
  assign bus.ifd_cache_miss            = miss_q;
  assign bus.ifd_cache_miss_paddr      = miss_paddr_q;
  assign bus.ifd_cache_miss_thread_idx = tid_q;
  assign bus.ifd_near_miss             = near_miss;
  assign bus.ifd_update_lru_en         = bus.ift_instruction_requested && hit;
  assign bus.ifd_update_lru_way        = hit_way;
  assign bus.ifd_invalidate_en         = par_err;
  assign bus.ifd_invalidate_way        = way_q;
  assign bus.ifd_invalidate_set        = set_q;
  assign bus.ifd_parity_error          = par_err;
endmodule
